// File: rtl/alu_seq_ctrl_pkg.sv
// alu_seq_ctrl_pkg: states, ROM word layout, condition codes and ALU output bundle for the sequencer
// Optional PAUSE state exists only when ALU_SEQ_SINGLE_STEP_EN is defined.
package alu_seq_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_FLAGS, S_HALT
`ifdef ALU_SEQ_SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_e;
  typedef struct packed {
    logic       ctl;
    logic       chain;
    logic [2:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic       rsvd;
    logic [7:0] k;
  } word_t;
  typedef struct packed {
    logic z;
    logic c;
    logic v;
    logic n;
  } flags_t;
  typedef struct packed {
    logic [2:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic [7:0] k;
    logic       cin;
    logic       zin;
  } alu_t;
  localparam logic [2:0] NOP_OP = 3'b000;
  localparam alu_t ALU_NOP = '{op: NOP_OP, a: 3'd0, b: 3'd0, k: 8'd0, cin: 1'b0, zin: 1'b1};
  localparam logic [2:0] C_JMP = 3'd0, C_JZ = 3'd1, C_JNZ = 3'd2, C_JC = 3'd3,
                         C_JNC = 3'd4, C_JN = 3'd5, C_JV = 3'd6, C_HALT = 3'd7;
endpackage

// File: rtl/alu_seq_ctrl_cond.sv
// alu_seq_ctrl_cond: combinational jump-condition evaluation (cond, flags -> taken)
// Ports: cond (3b condition code), flags (captured z/c/v/n), taken (jump taken; HALT code never taken).
module alu_seq_ctrl_cond
  import alu_seq_ctrl_pkg::*;
(
  input  logic [2:0] cond,
  input  flags_t     flags,
  output logic       taken
);
  always_comb taken = cond == C_JMP ? 1'b1 :
                      cond == C_JZ  ? flags.z :
                      cond == C_JNZ ? !flags.z :
                      cond == C_JC  ? flags.c :
                      cond == C_JNC ? !flags.c :
                      cond == C_JN  ? flags.n :
                      cond == C_JV  ? flags.v : 1'b0;
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle instruction sequencer fetching 20-bit ROM words and driving an 8-bit ALU
// Ports: clk, rst (sync, active-high), start; rom_en/rom_addr out, rom_data in (one cycle after rom_en);
//  alu_op/alu_a_addr/alu_b_addr/alu_const/alu_cin/alu_zero_in out (NOP pattern outside EXEC);
//  alu_zero/alu_cout/alu_ovf/alu_neg in (registered ALU flags); busy, halted out.
// Macro ALU_SEQ_SINGLE_STEP_EN adds input step and a PAUSE state between instructions.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
`ifdef ALU_SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic            rom_en,
  output logic [PC_W-1:0] rom_addr,
  input  logic [19:0]     rom_data,
  output logic [2:0]      alu_op,
  output logic [2:0]      alu_a_addr,
  output logic [2:0]      alu_b_addr,
  output logic [7:0]      alu_const,
  output logic            alu_cin,
  output logic            alu_zero_in,
  input  logic            alu_zero,
  input  logic            alu_cout,
  input  logic            alu_ovf,
  input  logic            alu_neg,
  output logic            busy,
  output logic            halted
);
`ifdef ALU_SEQ_SINGLE_STEP_EN
  localparam state_e S_RESUME = S_PAUSE;
`else
  localparam state_e S_RESUME = S_FETCH;
`endif
  state_e          state_q;
  logic [PC_W-1:0] pc_q, pc_inc, pc_jmp;
  flags_t          flags_q;
  alu_t            alu_q;
  word_t           w;
  logic            taken, unused_rsvd;
  assign w           = rom_data;
  assign unused_rsvd = w.rsvd;
  assign pc_inc      = pc_q + PC_W'(1);
  assign pc_jmp      = PC_W'(w.k);
  assign rom_en      = state_q == S_FETCH;
  assign rom_addr    = pc_q;
  assign busy        = state_q != S_IDLE && state_q != S_HALT;
  assign halted      = state_q == S_HALT;
  assign alu_op      = alu_q.op;
  assign alu_a_addr  = alu_q.a;
  assign alu_b_addr  = alu_q.b;
  assign alu_const   = alu_q.k;
  assign alu_cin     = alu_q.cin;
  assign alu_zero_in = alu_q.zin;
  alu_seq_ctrl_cond u_cond (.cond(w.op), .flags(flags_q), .taken(taken));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      flags_q <= '0;
      alu_q   <= ALU_NOP;
    end else begin
      alu_q <= ALU_NOP;
      case (state_q)
        S_IDLE, S_HALT: if (start) begin
          state_q <= S_FETCH;
          pc_q    <= '0;
          flags_q <= '0;
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: if (!w.ctl) begin
          state_q <= S_EXEC;
          alu_q   <= '{op: w.op, a: w.a, b: w.b, k: w.k, cin: w.chain & flags_q.c,
                       zin: w.chain ? flags_q.z : 1'b1};
        end else if (w.op == C_HALT) begin
          state_q <= S_HALT;
        end else begin
          state_q <= S_RESUME;
          pc_q    <= taken ? pc_jmp : pc_inc;
        end
        S_EXEC: state_q <= S_FLAGS;
        S_FLAGS: begin
          flags_q <= {alu_zero, alu_cout, alu_ovf, alu_neg};
          pc_q    <= pc_inc;
          state_q <= S_RESUME;
        end
`ifdef ALU_SEQ_SINGLE_STEP_EN
        S_PAUSE: if (step) state_q <= S_FETCH;
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: scoreboard bench with a program-interpreter reference model and a stub ALU
`timescale 1ns/1ps
module tb_alu_seq_ctrl;
  localparam int PC_W = 6;
  localparam int DEPTH = 1 << PC_W;
  localparam logic [18:0] NOP19 = 19'h1;
`ifdef ALU_SEQ_SINGLE_STEP_EN
  localparam int PX = 1;
  logic step;
`else
  localparam int PX = 0;
`endif
  logic clk = 0, rst, start;
  logic rom_en;
  logic [PC_W-1:0] rom_addr;
  logic [19:0] rom_data;
  logic [2:0] alu_op, alu_a_addr, alu_b_addr;
  logic [7:0] alu_const;
  logic alu_cin, alu_zero_in, alu_zero, alu_cout, alu_ovf, alu_neg, busy, halted;
  logic [19:0] rom [DEPTH];
  typedef struct {
    int kind;
    int addr;
    int gap;
    logic [18:0] alu;
  } ev_t;
  ev_t q[$];
  int total = 0, bad = 0;
  bit open_end = 0;
  always #5 clk = ~clk;
  alu_seq_ctrl #(.PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef ALU_SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .alu_op(alu_op), .alu_a_addr(alu_a_addr), .alu_b_addr(alu_b_addr), .alu_const(alu_const),
    .alu_cin(alu_cin), .alu_zero_in(alu_zero_in),
    .alu_zero(alu_zero), .alu_cout(alu_cout), .alu_ovf(alu_ovf), .alu_neg(alu_neg),
    .busy(busy), .halted(halted)
  );
  // x = {op,a,b,const,cin,zin}; returns {z,c,v,n}
  function automatic logic [3:0] stub_flags(logic [18:0] x);
    logic [8:0] t;
    t = {1'b0, x[9:2]} + {3'b0, x[18:13]} + {8'b0, x[1]};
    return {x[0] & (t[1:0] == 2'b00), t[8] ^ x[2], ^t[7:0], t[7]};
  endfunction
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];
  always @(posedge clk)
    {alu_zero, alu_cout, alu_ovf, alu_neg} <=
      stub_flags({alu_op, alu_a_addr, alu_b_addr, alu_const, alu_cin, alu_zero_in});
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  // Interprets the ROM program from PC 0 with cleared flags, queueing expected fetch/exec/halt events.
  task automatic build(int max_n);
    int pc, gap, c;
    logic [3:0] fl;
    logic [19:0] w;
    logic [18:0] x;
    bit tk;
    pc = 0; gap = 0; fl = 4'b0;
    for (int n = 0; n < max_n; n++) begin
      w = rom[pc];
      q.push_back('{0, pc, gap, 19'd0});
      if (!w[19]) begin
        x = {w[17:9], w[7:0], w[18] & fl[2], w[18] ? fl[3] : 1'b1};
        q.push_back('{1, 0, 0, x});
        fl = stub_flags(x);
        pc = (pc + 1) % DEPTH;
        gap = 4 + PX;
      end else begin
        c = int'(w[17:15]);
        if (c == 7) begin
          q.push_back('{2, 0, 0, 19'd0});
          open_end = 0;
          return;
        end
        case (c)
          0: tk = 1;
          1: tk = fl[3];
          2: tk = !fl[3];
          3: tk = fl[2];
          4: tk = !fl[2];
          5: tk = fl[0];
          default: tk = fl[1];
        endcase
        pc = tk ? int'(w[7:0]) % DEPTH : (pc + 1) % DEPTH;
        gap = 2 + PX;
      end
    end
    open_end = 1;
  endtask
  int cyc = 0;
  bit was_h = 0;
  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      cyc = 0;
      was_h = 0;
    end else if (!(open_end && q.size() == 0)) begin
      cyc++;
      if (rom_en) begin
        if (q.size() == 0 || q[0].kind != 0) begin
          total++; bad++;
          $display("FAIL fetch_unexpected: got fetch at %0h want none", rom_addr);
        end else begin
          e = q.pop_front();
          chk("fetch_addr", 32'(rom_addr), e.addr);
          if (e.gap != 0) chk("fetch_gap", cyc, e.gap);
        end
        cyc = 0;
      end
      if (cyc == 2 && q.size() > 0 && q[0].kind == 1) begin
        e = q.pop_front();
        chk("exec_outputs", {alu_op, alu_a_addr, alu_b_addr, alu_const, alu_cin, alu_zero_in}, e.alu);
      end else begin
        chk("nop_outputs", {alu_op, alu_a_addr, alu_b_addr, alu_const, alu_cin, alu_zero_in}, NOP19);
      end
      if (halted && !was_h) begin
        if (q.size() == 0 || q[0].kind != 2) begin
          total++; bad++;
          $display("FAIL halt_unexpected: got halted=1 want 0");
        end else begin
          void'(q.pop_front());
          chk("halt_timing", cyc, 2);
          chk("halt_busy", busy, 0);
        end
      end
      was_h = halted;
    end
  end
  task automatic drain(int lim);
    int n = 0;
    while (q.size() > 0 && n < lim) begin
      tick;
      n++;
    end
    if (q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d events left want 0", q.size());
      q.delete();
    end
  endtask
  task automatic chk_reset(string t);
    chk({t, "_rom_en"}, rom_en, 0);
    chk({t, "_rom_addr"}, 32'(rom_addr), 0);
    chk({t, "_alu_op"}, alu_op, 0);
    chk({t, "_alu_a"}, alu_a_addr, 0);
    chk({t, "_alu_b"}, alu_b_addr, 0);
    chk({t, "_alu_const"}, alu_const, 0);
    chk({t, "_alu_cin"}, alu_cin, 0);
    chk({t, "_alu_zero_in"}, alu_zero_in, 1);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_halted"}, halted, 0);
  endtask
  task automatic pulse_start;
    start = 1;
    tick;
    start = 0;
  endtask
  initial begin
    int i;
    rst = 1; start = 0;
`ifdef ALU_SEQ_SINGLE_STEP_EN
    step = 1;
`endif
    foreach (rom[k]) rom[k] = 20'h0;
    repeat (3) tick;
    chk_reset("por");
    rst = 0;
    tick;
    chk_reset("idle");
    // Fixed program: plain ALU, chained ALU, JZ/JNZ to 63 (0x7F truncated), ALU at 63 wraps to 0.
    rom[0]  = {1'b0, 1'b0, 3'd7, 3'd1, 3'd2, 1'b0, 8'h00};
    rom[1]  = {1'b0, 1'b1, 3'd1, 3'd3, 3'd4, 1'b0, 8'h55};
    rom[2]  = {1'b1, 1'b0, 3'd1, 3'd0, 3'd0, 1'b0, 8'h3F};
    rom[3]  = {1'b1, 1'b0, 3'd2, 3'd0, 3'd0, 1'b1, 8'h7F};
    rom[63] = {1'b0, 1'b1, 3'd2, 3'd5, 3'd6, 1'b0, 8'hFE};
    build(25);
    pulse_start;
    chk("start_busy", busy, 1);
    chk("start_rom_en", rom_en, 1);
    chk("start_addr", 32'(rom_addr), 0);
    repeat (5) tick;
    pulse_start;
    drain(300);
    i = 0;
    while (alu_op != 3'd7 && i < 60) begin
      tick;
      i++;
    end
    chk("exec_seen_op", alu_op, 7);
    rst = 1;
    tick;
    chk_reset("rst_exec");
    rst = 0;
    tick;
    chk("rst_exec_idle_busy", busy, 0);
    // Halt program: chained ALU sets C, JC to 5, HALT; restart must begin with cleared flags.
    foreach (rom[k]) rom[k] = 20'h0;
    rom[0] = {1'b0, 1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 8'h01};
    rom[1] = {1'b1, 1'b0, 3'd3, 3'd0, 3'd0, 1'b0, 8'h05};
    rom[5] = {1'b1, 1'b0, 3'd7, 3'd0, 3'd0, 1'b0, 8'h00};
    for (int r = 0; r < 2; r++) begin
      build(10);
      pulse_start;
      chk("halt_prog_addr", 32'(rom_addr), 0);
      drain(100);
      tick;
      chk("halted_flag", halted, 1);
      chk("halted_busy", busy, 0);
      chk("halted_rom_en", rom_en, 0);
    end
    // Random programs; reset lands wherever the program happens to be.
    for (int r = 0; r < 8; r++) begin
      rst = 1;
      tick;
      chk_reset("rand_rst");
      rst = 0;
      foreach (rom[k]) rom[k] = 20'($urandom);
      build(60);
      pulse_start;
      drain(60 * (5 + PX) + 20);
      repeat ($urandom_range(0, 7)) tick;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
